msg_encoder: RTL
================

# msg_encoder

Frame builder that sits downstream of up to N SPI/serial interface blocks on `sys_clk`. It round-robins over their show-ahead slave FIFOs, reads one pending message at a time and emits a framed byte stream to the host transmitter: SYNC, channel id, length, payload, checksum. It is the consumer of each interface's `have_msg`/`len`/`out_data` and the driver of its `enc_rdreq`.

## Interface
Parameters:
- `N_CH`, 4: number of interface channels, 1..8.
- `SYNC`, 8'hA5: first byte of every frame.
- `CH_BASE`, 8'h10: id byte for channel k is `CH_BASE + k` (mod 256).
- `MAX_LEN`, 8'd255: payload cap per frame; latched length is `min(len, MAX_LEN)`; must be ≥1.

Ports:
- `n_rst`  in  1  async reset, active low.
- `sys_clk`  in  1  the single clock.
- `have_msg`  in  N_CH  per-channel FIFO not-empty.
- `len`  in  8*N_CH  per-channel fill count; channel k at `[8k+7:8k]`.
- `in_data`  in  8*N_CH  per-channel show-ahead FIFO head byte.
- `enc_rdreq`  out  N_CH  per-channel pop, one-hot or zero.
- `tx_data`  out  8  frame byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts the byte.
- `busy`  out  1  frame in progress, i.e. state ≠ IDLE.

Clock and reset: one clock `sys_clk`; reset `n_rst` is asynchronous and active-low.

## Operation
- Channel k is eligible when `have_msg[k] && len[k] != 0`. A zero `len` with `have_msg` high, from dc_fifo usedw lag, is not eligible.
- States: IDLE → SYNC → ID → LEN → DATA → CSUM → IDLE.
- IDLE: if any channel is eligible, the rr_arbiter grants the first eligible channel after the last served one, wrapping. On grant, latch `ch`, `cnt = min(len[ch], MAX_LEN)` and `csum = 0`, then go to SYNC. Priority after reset starts at channel 0.
- Output register: a new byte is loaded only when `!tx_valid || tx_ready`. A byte is transferred on `tx_valid && tx_ready`. While stalled, `tx_data` and `tx_valid` hold.
- SYNC loads `SYNC`. ID loads `CH_BASE+ch`. LEN loads `cnt`. DATA loads `in_data[ch]` and asserts `enc_rdreq[ch]` in the same cycle, once per byte, `cnt` times. CSUM loads `csum`.
- `csum` is the 8-bit sum, mod 256, of the ID, LEN and all payload bytes. SYNC is excluded.
- After CSUM is loaded, go to IDLE. IDLE may grant the next frame while the CSUM byte is still waiting in the output register.
- Only latched `cnt` bytes are sent. Bytes written to the FIFO during a frame stay for a later frame.
- `enc_rdreq` is never asserted outside DATA and never on a non-granted channel.
- Reset mid-frame: the partial frame is abandoned with no flush. FIFO bytes already popped are lost; this is accepted.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0`, `enc_rdreq=0`, `busy=0`, state IDLE, rr pointer = channel N_CH-1, so channel 0 has first priority.
- Grant latency: eligible channel in IDLE at edge t → state SYNC at t+1 → `tx_valid` with SYNC at t+2.
- With `tx_ready` held at 1: one byte per cycle, frame length L+4 cycles, at most 1 idle cycle between back-to-back frames.
- DATA pop: `enc_rdreq` pulses in the cycle the head byte is captured. The show-ahead FIFO presents the next byte by the next edge, so consecutive pops are legal on consecutive cycles.
- Stalled DATA: no pop while `tx_valid && !tx_ready`.

## Structure
- Shared package/header `msg_enc_pkg`: state encoding localparams (IDLE, SYNC, ID, LEN, DATA, CSUM) and the default SYNC constant.
- One sub-module, `rr_arbiter`: parameter N, inputs request vector and last-grant index, outputs one-hot grant and `any`. It is combinational; the pointer register stays in msg_encoder.

## Test plan
- Single message: ch0 FIFO holds 01 02 03, len=3, tx_ready=1 → A5 10 03 01 02 03 19, three `enc_rdreq[0]` pulses, `busy` low after.
- Backpressure: same stimulus with tx_ready toggling 1,0,0,1… → identical byte sequence. Each byte holds stable while stalled, and there is no pop during a stall.
- Round robin: ch1, ch2 and ch3 each hold 1 byte (AA, BB, CC) → frame order ch1, ch2, ch3. Refill ch1 while serving ch2 → ch1 is served after ch3.
- Length lag: have_msg[0]=1, len[0]=0 for 5 cycles → no grant. Then len=1 with byte 7F → A5 10 01 7F 90.
- Growth and cap: MAX_LEN=4, len=6 at grant, 2 more bytes written mid-frame → payload of 4 bytes. The next frame carries the remaining 4 bytes, since len is re-sampled as 4.
- Reset mid-DATA: assert n_rst=0 after 2 payload bytes → all outputs take reset values immediately. After release, the next grant goes to ch0 if it is eligible.

Source files
------------

// File: rtl/msg_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msg_enc_pkg
//  Description : Shared definitions for the message frame encoder.
//                Holds the frame-builder state encoding, the default SYNC
//                byte and a small helper that caps a FIFO fill count.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package msg_enc_pkg;

    // Frame-builder states, in the order the bytes leave the block.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_ID   = 3'd2,
        ST_LEN  = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5
    } enc_state_e;

    localparam logic [7:0] c_SYNC_DEFAULT = 8'hA5;

    // Payload length actually sent for a frame: min(fill count, cap).
    function automatic logic [7:0] cap_len(input logic [7:0] fill,
                                           input logic [7:0] cap);
        return (fill > cap) ? cap : fill;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msg_encoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first
//                requesting channel strictly after the last-served index,
//                wrapping, so the last-served channel has lowest priority.
//  Ports       : i_req   [N-1:0]  request vector
//                i_last  [IW-1:0] index of the last granted channel
//                o_grant [N-1:0]  one-hot grant (zero when no request)
//                o_any            at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic          o_any
);

    always_comb begin
        int   idx;
        logic found;
        o_grant = '0;
        found   = 1'b0;
        idx     = 0;
        // i runs 1..N so the search starts just after the last winner and
        // reaches the last winner itself only as the final candidate.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(i_last) + i) % N;
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/msg_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : msg_encoder
//  Description : Round-robin frame builder over N_CH show-ahead FIFOs.
//                Emits SYNC, channel id, length, payload, checksum per
//                message through a single ready/valid output register.
//  Ports       : n_rst           async reset, active low
//                sys_clk         clock
//                have_msg [N]    per-channel FIFO not-empty
//                len      [8N]   per-channel fill count, ch k at [8k+7:8k]
//                in_data  [8N]   per-channel FIFO head byte
//                enc_rdreq[N]    per-channel pop (one-hot or zero)
//                tx_data  [8]    frame byte
//                tx_valid        tx_data valid
//                tx_ready        sink accepts byte
//                busy            frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_encoder
    import msg_enc_pkg::*;
#(
    parameter int         N_CH    = 4,
    parameter logic [7:0] SYNC    = c_SYNC_DEFAULT,
    parameter logic [7:0] CH_BASE = 8'h10,
    parameter logic [7:0] MAX_LEN = 8'd255
) (
    input  logic              n_rst,
    input  logic              sys_clk,
    input  logic [N_CH-1:0]   have_msg,
    input  logic [8*N_CH-1:0] len,
    input  logic [8*N_CH-1:0] in_data,
    output logic [N_CH-1:0]   enc_rdreq,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);

    localparam int c_IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    enc_state_e        state_q, state_d;
    logic [c_IW-1:0]   ch_q, ch_d;
    logic [c_IW-1:0]   last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;

    logic [7:0]        w_len_arr  [N_CH];
    logic [7:0]        w_data_arr [N_CH];
    logic [N_CH-1:0]   w_elig;
    logic [N_CH-1:0]   w_grant;
    logic              w_any;
    logic [c_IW-1:0]   w_gnt_idx;
    logic              w_load;
    logic [7:0]        w_id_byte;
    logic [7:0]        w_pay_byte;

    // A zero fill count with have_msg high comes from usedw lag in the
    // dual-clock FIFO; such a channel must not be granted yet.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign w_len_arr[k]  = len[8*k +: 8];
        assign w_data_arr[k] = in_data[8*k +: 8];
        assign w_elig[k]     = have_msg[k] && (w_len_arr[k] != 8'd0);
    end

    rr_arbiter #(
        .N  (N_CH),
        .IW (c_IW)
    ) u_arb (
        .i_req   (w_elig),
        .i_last  (last_q),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_grant[k]) w_gnt_idx = c_IW'(k);
        end
    end

    // Output register may take a new byte when empty or being drained.
    assign w_load     = !tx_valid_q || tx_ready;
    assign w_id_byte  = CH_BASE + 8'(ch_q);
    assign w_pay_byte = w_data_arr[ch_q];

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !tx_ready;
        enc_rdreq  = '0;
        case (state_q)
            ST_IDLE: begin
                // Granting here does not wait for the CSUM byte to drain.
                if (w_any) begin
                    ch_d    = w_gnt_idx;
                    last_d  = w_gnt_idx;
                    cnt_d   = cap_len(w_len_arr[w_gnt_idx], MAX_LEN);
                    csum_d  = 8'd0;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_load) begin
                    tx_data_d  = SYNC;
                    tx_valid_d = 1'b1;
                    state_d    = ST_ID;
                end
            end
            ST_ID: begin
                if (w_load) begin
                    tx_data_d  = w_id_byte;
                    tx_valid_d = 1'b1;
                    csum_d     = csum_q + w_id_byte;
                    state_d    = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_load) begin
                    tx_data_d  = cnt_q;
                    tx_valid_d = 1'b1;
                    csum_d     = csum_q + cnt_q;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                // Pop in the same cycle the head byte is captured; the
                // show-ahead FIFO presents the next byte by the next edge.
                if (w_load) begin
                    tx_data_d        = w_pay_byte;
                    tx_valid_d       = 1'b1;
                    enc_rdreq[ch_q]  = 1'b1;
                    csum_d           = csum_q + w_pay_byte;
                    cnt_d            = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (w_load) begin
                    tx_data_d  = csum_q;
                    tx_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            last_q     <= c_IW'(N_CH - 1);
            cnt_q      <= 8'd0;
            csum_q     <= 8'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire
